ssd_scan_mux: RTL

Time-multiplexed scanner for a multi-digit common-anode seven-segment display. It holds a DIGITS-nibble display value and presents one 4-bit hex digit at a time to the downstream hex-to-7-segment decoder (`digit_hex` drives the decoder's 4-bit `sw` input). It drives the matching active-low digit enable. New values are accepted through a load/ack handshake and applied only at frame boundaries, so a scan frame never mixes old and new digits.

---
 rtl/ssd_scan_mux.sv | 107 ++++++++++
 1 files changed

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed scanner for a common-anode seven-segment
// display. One nibble at a time is presented to a downstream combinational
// hex decoder, together with an active-low one-hot digit enable. New values
// are staged and swapped in only at frame wrap, so a frame never mixes old
// and new digits.
// Optional feature: define SSD_SCAN_LZB_EN for leading-zero blanking.
module ssd_scan_mux #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   output logic                  load_ack,
   output logic [3:0]            digit_hex,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [PW-1:0]       presc;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] disp;
   logic [4*DIGITS-1:0] shadow;
   logic                pending;

   logic                tick;
   logic                wrap;
   logic [IW-1:0]       idx_n;
   logic [4*DIGITS-1:0] disp_n;
   logic [3:0]          hex_n;
   logic [DIGITS-1:0]   en_n;
`ifdef SSD_SCAN_LZB_EN
   logic [IW-1:0]       msd;
`endif

   // Next-state index/value; outputs are derived from these so they change
   // on the same edge that advances the scan.
   always_comb begin
      tick   = (presc == PRESC_MAX);
      wrap   = tick && (idx == IDX_MAX);
      idx_n  = idx;
      if (tick)
         idx_n = wrap ? '0 : idx + 1'b1;
      // A load on the wrap edge itself wins over any older staged value.
      disp_n = disp;
      if (wrap) begin
         if (load)
            disp_n = value;
         else if (pending)
            disp_n = shadow;
      end
      hex_n = 4'h0;
      en_n  = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_n == IW'(k)) begin
            hex_n   = disp_n[4*k +: 4];
            en_n[k] = 1'b0;
         end
      end
`ifdef SSD_SCAN_LZB_EN
      // Digit 0 is never blanked: msd stays 0 for an all-zero value.
      msd = '0;
      for (int k = 1; k < DIGITS; k++) begin
         if (disp_n[4*k +: 4] != 4'h0)
            msd = IW'(k);
      end
      if (idx_n > msd)
         en_n = '1;
`endif
   end

   // Scan state, staging handshake and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc     <= '0;
         idx       <= '0;
         disp      <= '0;
         shadow    <= '0;
         pending   <= 1'b0;
         load_ack  <= 1'b0;
         frame     <= 1'b0;
         digit_hex <= 4'h0;
         digit_en  <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         presc     <= tick ? '0 : presc + 1'b1;
         idx       <= idx_n;
         disp      <= disp_n;
         if (load && !wrap)
            shadow <= value;
         if (wrap)
            pending <= 1'b0;
         else if (load)
            pending <= 1'b1;
         load_ack  <= wrap && (load || pending);
         frame     <= wrap;
         digit_hex <= hex_n;
         digit_en  <= en_n;
      end
   end

endmodule
